// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock hour paths.
// Contents:
//   state_t      - hour-set FSM encodings (IDLE, EDIT, COMMIT)
//   BCD_12/23    - BCD hour constants
//   h12_t        - 12-hour BCD hour plus AM/PM flag
//   h12_to_h24   - 12h BCD + PM -> 24h BCD (00..23)
//   h24_to_h12   - 24h BCD -> 12h BCD + PM; out-of-range input maps to 12AM
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;

  typedef struct packed {
    logic [3:0] hh;
    logic [3:0] hl;
    logic       pm;
  } h12_t;

  // Pure BCD digit manipulation: the ports never carry a binary hour.
  function automatic logic [7:0] h12_to_h24(input logic [3:0] hh,
                                            input logic [3:0] hl,
                                            input logic pm);
    logic [7:0] r;
    if (!pm)                     r = ({hh, hl} == BCD_12) ? 8'h00 : {hh, hl};
    else if ({hh, hl} == BCD_12) r = BCD_12;
    else if (hh == 4'd0 && hl <= 4'd7) r = {4'd1, hl + 4'd2};  // 1..7PM -> 13..19
    else if (hh == 4'd0)         r = {4'd2, hl - 4'd8};        // 8,9PM  -> 20,21
    else                         r = {4'd2, hl + 4'd2};        // 10,11PM -> 22,23
    return r;
  endfunction

  function automatic h12_t h24_to_h12(input logic [3:0] th, input logic [3:0] tl);
    h12_t r;
    logic valid;
    valid = (th <= 4'd2) && (tl <= 4'd9) && ({th, tl} <= BCD_23);
    r.hh = 4'd1;
    r.hl = 4'd2;
    r.pm = 1'b0;
    if (valid && {th, tl} != 8'h00) begin
      if (th == 4'd0) begin
        r.hh = 4'd0; r.hl = tl;
      end else if (th == 4'd1 && tl <= 4'd1) begin
        r.hh = 4'd1; r.hl = tl;
      end else if ({th, tl} == BCD_12) begin
        r.pm = 1'b1;
      end else if (th == 4'd1) begin
        r.hh = 4'd0; r.hl = tl - 4'd2; r.pm = 1'b1;  // 13..19 -> 1..7PM
      end else if (tl <= 4'd1) begin
        r.hh = 4'd0; r.hl = tl + 4'd8; r.pm = 1'b1;  // 20,21 -> 8,9PM
      end else begin
        r.hh = 4'd1; r.hl = tl - 4'd2; r.pm = 1'b1;  // 22,23 -> 10,11PM
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hour_set_12to24_if.sv
// Load handshake between the hour-set block and the hour counter.
//   LoadReq  - request, held until acknowledged (master -> slave)
//   H24H/L   - 24h BCD hour, stable while LoadReq is high (master -> slave)
//   LoadAck  - hour counter has taken H24H/H24L (slave -> master)
interface hour_set_12to24_if;
  logic       LoadReq;
  logic       LoadAck;
  logic [3:0] H24H;
  logic [3:0] H24L;

  modport master (output LoadReq, output H24H, output H24L, input LoadAck);
  modport slave  (input LoadReq, input H24H, input H24L, output LoadAck);
endinterface

// File: rtl/bcd_hour_12to24.sv
// Combinational 12h -> 24h BCD hour converter.
// Ports: H12H/H12L/PM in (12h BCD hour + PM flag), H24H/H24L out (24h BCD).
import clock_pkg::*;

module bcd_hour_12to24 (
  input  logic [3:0] H12H,
  input  logic [3:0] H12L,
  input  logic       PM,
  output logic [3:0] H24H,
  output logic [3:0] H24L
);
  assign {H24H, H24L} = h12_to_h24(H12H, H12L, PM);
endmodule

// File: rtl/hour_set_12to24.sv
// Hour-setting front end for 12-hour display mode. The user edits a BCD
// hour 1..12 plus AM/PM with Set/Up/Down; on leaving edit the value is
// converted to 24h BCD and offered to the hour counter via req/ack.
// Ports:
//   CP, nCR            - clock (rising edge), asynchronous active-low reset
//   Set, Up, Down      - debounced level keys, acted on at rising edges
//   CurH, CurL         - current 24h hour from the hour counter
//   H12H, H12L, PM     - edited 12h hour and PM flag
//   Editing            - high while editing
//   load (master)      - LoadReq/LoadAck handshake carrying H24H/H24L
// Build option: HOUR_SET_AUTO_EXIT_EN commits automatically after
// TIMEOUT_CYC cycles in edit without an Up/Down edge.
import clock_pkg::*;

module hour_set_12to24 #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               CP,
  input  logic               nCR,
  input  logic               Set,
  input  logic               Up,
  input  logic               Down,
  input  logic [3:0]         CurH,
  input  logic [3:0]         CurL,
  output logic [3:0]         H12H,
  output logic [3:0]         H12L,
  output logic               PM,
  output logic               Editing,
  hour_set_12to24_if.master  load
);

  function automatic h12_t step_up(input h12_t h);
    h12_t r;
    r = h;
    if ({h.hh, h.hl} == BCD_12) begin
      r.hh = 4'd0; r.hl = 4'd1;                 // 12 -> 1 keeps AM/PM
    end else if ({h.hh, h.hl} == 8'h11) begin
      r.hh = 4'd1; r.hl = 4'd2; r.pm = ~h.pm;   // 11 -> 12 flips AM/PM
    end else if (h.hl == 4'd9) begin
      r.hh = 4'd1; r.hl = 4'd0;
    end else begin
      r.hl = h.hl + 4'd1;
    end
    return r;
  endfunction

  function automatic h12_t step_down(input h12_t h);
    h12_t r;
    r = h;
    if ({h.hh, h.hl} == 8'h01) begin
      r.hh = 4'd1; r.hl = 4'd2;
    end else if ({h.hh, h.hl} == BCD_12) begin
      r.hh = 4'd1; r.hl = 4'd1; r.pm = ~h.pm;
    end else if ({h.hh, h.hl} == 8'h10) begin
      r.hh = 4'd0; r.hl = 4'd9;
    end else begin
      r.hl = h.hl - 4'd1;
    end
    return r;
  endfunction

  state_t     state_reg;
  logic       set_d, up_d, down_d;
  logic       set_e, up_e, down_e;
  logic       timeout;
  logic [3:0] conv_h, conv_l;
  h12_t       cur_h12, cur_edit;

  assign set_e  = Set  & ~set_d;
  assign up_e   = Up   & ~up_d;
  assign down_e = Down & ~down_d;

  assign cur_h12  = h24_to_h12(CurH, CurL);
  assign cur_edit = '{hh: H12H, hl: H12L, pm: PM};

  bcd_hour_12to24 u_conv (
    .H12H (H12H),
    .H12L (H12L),
    .PM   (PM),
    .H24H (conv_h),
    .H24L (conv_l)
  );

`ifdef HOUR_SET_AUTO_EXIT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt;

  // The edge that brings the count to TIMEOUT_CYC is the commit edge.
  assign timeout = (state_reg == EDIT) && !up_e && !down_e &&
                   (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      idle_cnt <= '0;
    end else if (state_reg != EDIT || up_e || down_e) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  wire unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_reg    <= IDLE;
      set_d        <= 1'b0;
      up_d         <= 1'b0;
      down_d       <= 1'b0;
      H12H         <= 4'd1;
      H12L         <= 4'd2;
      PM           <= 1'b0;
      Editing      <= 1'b0;
      load.LoadReq <= 1'b0;
      load.H24H    <= 4'd0;
      load.H24L    <= 4'd0;
    end else begin
      set_d  <= Set;
      up_d   <= Up;
      down_d <= Down;
      case (state_reg)
        IDLE: begin
          {H12H, H12L, PM} <= cur_h12;
          if (set_e) begin
            state_reg <= EDIT;
            Editing   <= 1'b1;
          end
        end
        EDIT: begin
          if (set_e || timeout) begin
            // Up/Down in the same cycle is dropped; commit the shown value.
            state_reg    <= COMMIT;
            Editing      <= 1'b0;
            load.LoadReq <= 1'b1;
            load.H24H    <= conv_h;
            load.H24L    <= conv_l;
          end else if (up_e && !down_e) begin
            {H12H, H12L, PM} <= step_up(cur_edit);
          end else if (down_e && !up_e) begin
            {H12H, H12L, PM} <= step_down(cur_edit);
          end
        end
        COMMIT: begin
          if (load.LoadAck) begin
            state_reg    <= IDLE;
            load.LoadReq <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          Editing      <= 1'b0;
          load.LoadReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
